// File: rtl/operand_skewer_pkg.sv
// Shared types and helpers for the operand skewer: FSM state encoding and
// the number of skewed beats needed to drain one matrix pair.
package operand_skewer_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // A wavefront needs K beats plus one extra beat per additional lane.
  function automatic int beat_count(input int k, input int h, input int w);
    return k + ((h > w) ? h : w) - 1;
  endfunction

endpackage

// File: rtl/operand_skewer_if.sv
// Handshake bundle between the upstream operand FIFO, the skewer and the
// systolic array. The slave modport is the skewer's view.
interface operand_skewer_if #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) ();

  logic                                valid_i;
  logic [width_p-1:0]                  data_i;
  logic                                yumi_o;
  logic [array_height_p*width_p-1:0]   row_o;
  logic [array_width_p*width_p-1:0]    col_o;
  logic                                valid_o;
  logic                                ready_i;
  logic                                flush_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output yumi_o, row_o, col_o, valid_o, flush_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  yumi_o, row_o, col_o, valid_o, flush_o
  );

endinterface

// File: rtl/operand_skewer_skew_select.sv
// One lane of the skew network: picks element (t - lane) of the lane's K
// operands, or zero when the wavefront has not reached or has passed it.
module operand_skewer_skew_select #(
  parameter int width_p  = 32,
  parameter int k_p      = 2,
  parameter int beat_w_p = 2,
  parameter int lane_p   = 0
) (
  input  logic [beat_w_p-1:0]    beat_i,
  input  logic [k_p*width_p-1:0] elems_i,
  output logic [width_p-1:0]     elem_o
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    elem_o = '0;
    for (int k = 0; k < k_p; k++) begin
      if (int'(beat_i) == lane_p + k) elem_o = elems_i[k*width_p +: width_p];
    end
  end

endmodule

// File: rtl/operand_skewer.sv
// Buffers an A (H x K) / B (K x W) operand pair from a FIFO and replays it as
// skewed wavefronts for a systolic array. Optional stall counter: OPERAND_SKEWER_STALL_CNT_EN.
module operand_skewer
  import operand_skewer_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int k_p            = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  operand_skewer_if.slave   bus
`ifdef OPERAND_SKEWER_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int h_lp           = array_height_p;
  localparam int w_lp           = array_width_p;
  localparam int a_words_lp     = h_lp * k_p;
  localparam int total_words_lp = a_words_lp + k_p * w_lp;
  localparam int beats_lp       = beat_count(k_p, h_lp, w_lp);
  localparam int word_w_lp      = $clog2(total_words_lp + 1);
  localparam int beat_w_lp      = $clog2(beats_lp + 1);

  localparam logic [word_w_lp-1:0] last_word_lp = word_w_lp'(total_words_lp - 1);
  localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(beats_lp - 1);

  state_e               state_q, state_d;
  logic [word_w_lp-1:0] word_q, word_d;
  logic [beat_w_lp-1:0] beat_q, beat_d;
  logic                 yumi;
  logic                 feed_valid;
  logic                 flush;

  // A occupies words [0, H*K), B follows at [H*K, H*K+K*W), both row-major.
  logic [width_p-1:0]   operand_mem [total_words_lp];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= LOAD;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    beat_d     = beat_q;
    yumi       = 1'b0;
    feed_valid = 1'b0;
    flush      = 1'b0;
    case (state_q)
      LOAD: begin
        // Reset is asynchronous, so the consume strobe is masked for its whole duration.
        yumi = bus.valid_i && !reset_i;
        if (yumi) begin
          if (word_q == last_word_lp) begin
            word_d  = '0;
            beat_d  = '0;
            state_d = FEED;
          end else begin
            word_d = word_q + word_w_lp'(1);
          end
        end
      end
      FEED: begin
        feed_valid = 1'b1;
        if (bus.ready_i) begin
          if (beat_q == last_beat_lp) begin
            beat_d  = '0;
            state_d = FLUSH;
          end else begin
            beat_d = beat_q + beat_w_lp'(1);
          end
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        word_d  = '0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: the operand buffer has no reset branch; its contents are only ever
  // read after a full reload, so clearing it would buy nothing.
  always_ff @(posedge clk_i) begin
    if (yumi) operand_mem[word_q] <= bus.data_i;
  end

  for (genvar i = 0; i < h_lp; i++) begin : g_row
    logic [k_p*width_p-1:0] elems;
    logic [width_p-1:0]     sel;
    for (genvar k = 0; k < k_p; k++) begin : g_k
      assign elems[k*width_p +: width_p] = operand_mem[i*k_p + k];
    end
    operand_skewer_skew_select #(
      .width_p (width_p),
      .k_p     (k_p),
      .beat_w_p(beat_w_lp),
      .lane_p  (i)
    ) u_sel (
      .beat_i (beat_q),
      .elems_i(elems),
      .elem_o (sel)
    );
    assign bus.row_o[i*width_p +: width_p] = feed_valid ? sel : '0;
  end

  for (genvar j = 0; j < w_lp; j++) begin : g_col
    logic [k_p*width_p-1:0] elems;
    logic [width_p-1:0]     sel;
    for (genvar k = 0; k < k_p; k++) begin : g_k
      assign elems[k*width_p +: width_p] = operand_mem[a_words_lp + k*w_lp + j];
    end
    operand_skewer_skew_select #(
      .width_p (width_p),
      .k_p     (k_p),
      .beat_w_p(beat_w_lp),
      .lane_p  (j)
    ) u_sel (
      .beat_i (beat_q),
      .elems_i(elems),
      .elem_o (sel)
    );
    assign bus.col_o[j*width_p +: width_p] = feed_valid ? sel : '0;
  end

  assign bus.yumi_o  = yumi;
  assign bus.valid_o = feed_valid;
  assign bus.flush_o = flush;

`ifdef OPERAND_SKEWER_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else if (feed_valid && !bus.ready_i) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_skewer.sv
// Directed, table-driven bench for operand_skewer with the default 2x2x2,
// 32-bit configuration.
module tb_operand_skewer;

  logic clk_i;
  logic reset_i;

  operand_skewer_if #(.width_p(32), .array_width_p(2), .array_height_p(2)) bus ();

`ifdef OPERAND_SKEWER_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  operand_skewer #(
    .width_p       (32),
    .array_width_p (2),
    .array_height_p(2),
    .k_p           (2)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .bus        (bus)
`ifdef OPERAND_SKEWER_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        vld_in;
    logic        rdy_in;
    logic        valid;
    logic        flush;
    logic [63:0] row;
    logic [63:0] col;
  } vec_t;

  vec_t vecs [21];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [63:0] p2(input logic [31:0] e0, input logic [31:0] e1);
    return {e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_vec(input int i, input logic vld, input logic rdy, input logic v,
                         input logic f, input logic [63:0] r, input logic [63:0] c);
    vecs[i] = '{vld_in: vld, rdy_in: rdy, valid: v, flush: f, row: r, col: c};
  endtask

  // Called at edge+1; returns at edge+1 after each consumed word.
  task automatic load_words(input int base, input int n, input bit toggle);
    for (int w = 0; w < n; w++) begin
      if (toggle) begin
        bus.valid_i = 1'b0;
        #1;
        check($sformatf("load%0d idle yumi_o", base + w), bus.yumi_o, 0);
        check($sformatf("load%0d idle valid_o", base + w), bus.valid_o, 0);
        @(posedge clk_i); #1;
      end
      bus.valid_i = 1'b1;
      bus.data_i  = 32'(base + w);
      #1;
      check($sformatf("load%0d yumi_o", base + w), bus.yumi_o, 1);
      check($sformatf("load%0d valid_o", base + w), bus.valid_o, 0);
      @(posedge clk_i); #1;
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.valid_i = vecs[i].vld_in;
      bus.ready_i = vecs[i].rdy_in;
      #1;
      check($sformatf("vec%0d valid_o", i), bus.valid_o, vecs[i].valid);
      check($sformatf("vec%0d flush_o", i), bus.flush_o, vecs[i].flush);
      check($sformatf("vec%0d yumi_o", i), bus.yumi_o, 0);
      check($sformatf("vec%0d row_o", i), bus.row_o, vecs[i].row);
      check($sformatf("vec%0d col_o", i), bus.col_o, vecs[i].col);
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    // Pair A=[[1,2],[3,4]] B=[[5,6],[7,8]], ready held high.
    set_vec(0,  0, 1, 1, 0, p2(1, 0), p2(5, 0));
    set_vec(1,  0, 1, 1, 0, p2(2, 3), p2(7, 6));
    set_vec(2,  0, 1, 1, 0, p2(0, 4), p2(0, 8));
    set_vec(3,  0, 1, 0, 1, 64'd0,    64'd0);
    set_vec(4,  0, 1, 0, 0, 64'd0,    64'd0);
    // Same pair with beat 1 stalled for two cycles.
    set_vec(5,  0, 1, 1, 0, p2(1, 0), p2(5, 0));
    set_vec(6,  0, 0, 1, 0, p2(2, 3), p2(7, 6));
    set_vec(7,  0, 0, 1, 0, p2(2, 3), p2(7, 6));
    set_vec(8,  0, 1, 1, 0, p2(2, 3), p2(7, 6));
    set_vec(9,  0, 1, 1, 0, p2(0, 4), p2(0, 8));
    set_vec(10, 0, 1, 0, 1, 64'd0,    64'd0);
    set_vec(11, 0, 1, 0, 0, 64'd0,    64'd0);
    // First of two back-to-back pairs: next word already pending.
    set_vec(12, 1, 1, 1, 0, p2(1, 0), p2(5, 0));
    set_vec(13, 1, 1, 1, 0, p2(2, 3), p2(7, 6));
    set_vec(14, 1, 1, 1, 0, p2(0, 4), p2(0, 8));
    set_vec(15, 1, 1, 0, 1, 64'd0,    64'd0);
    // Second pair A=[[11,12],[13,14]] B=[[15,16],[17,18]].
    set_vec(16, 0, 1, 1, 0, p2(11, 0),  p2(15, 0));
    set_vec(17, 0, 1, 1, 0, p2(12, 13), p2(17, 16));
    set_vec(18, 0, 1, 1, 0, p2(0, 14),  p2(0, 18));
    set_vec(19, 0, 1, 0, 1, 64'd0,      64'd0);
    set_vec(20, 0, 1, 0, 0, 64'd0,      64'd0);

    reset_i     = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'd0;
    bus.ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("reset yumi_o", bus.yumi_o, 0);
    check("reset valid_o", bus.valid_o, 0);
    check("reset flush_o", bus.flush_o, 0);
    check("reset row_o", bus.row_o, 0);
    check("reset col_o", bus.col_o, 0);
`ifdef OPERAND_SKEWER_STALL_CNT_EN
    check("reset stall_cnt_o", stall_cnt_o, 0);
`endif
    reset_i     = 1'b0;
    bus.valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Alternating valid_i; the first beat is the cycle after the last yumi.
    load_words(1, 8, 1'b1);
    run_vectors(0, 4);

    // Stalled beat 1 holds its data.
    load_words(1, 8, 1'b0);
    run_vectors(5, 11);
`ifdef OPERAND_SKEWER_STALL_CNT_EN
    check("stall_cnt_o after stall", stall_cnt_o, 2);
`endif

    // Reset with a partial pair buffered.
    load_words(21, 5, 1'b0);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'd26;
    reset_i     = 1'b1;
    #1;
    check("partial reset yumi_o", bus.yumi_o, 0);
    check("partial reset valid_o", bus.valid_o, 0);
    check("partial reset flush_o", bus.flush_o, 0);
    check("partial reset row_o", bus.row_o, 0);
    check("partial reset col_o", bus.col_o, 0);
`ifdef OPERAND_SKEWER_STALL_CNT_EN
    check("partial reset stall_cnt_o", stall_cnt_o, 0);
`endif
    @(posedge clk_i); #1;
    reset_i     = 1'b0;
    bus.valid_i = 1'b0;
    load_words(1, 8, 1'b0);
    run_vectors(0, 4);

    // Reset while presenting beat 1.
    load_words(1, 8, 1'b0);
    run_vectors(0, 0);
    reset_i = 1'b1;
    #1;
    check("feed reset valid_o", bus.valid_o, 0);
    check("feed reset flush_o", bus.flush_o, 0);
    check("feed reset row_o", bus.row_o, 0);
    check("feed reset col_o", bus.col_o, 0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("post reset%0d valid_o", c), bus.valid_o, 0);
      check($sformatf("post reset%0d flush_o", c), bus.flush_o, 0);
      @(posedge clk_i); #1;
    end
    load_words(1, 8, 1'b0);
    run_vectors(0, 4);

    // Back-to-back pairs with valid_i held high throughout.
    load_words(1, 8, 1'b0);
    bus.data_i = 32'd11;
    run_vectors(12, 15);
    load_words(11, 8, 1'b0);
    run_vectors(16, 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
